// File: rtl/alu_op_sequencer.sv
// Purpose: clocked front end for a 4-bit 16-function ALU; issues one op, waits, captures result/carry/decode check.
// Latency: rsp_valid rises after edge N+SETTLE_CYCLES+1 (N = accept edge); one op in flight at a time.
// Backpressure: req_ready only in IDLE; response held stable in RESP until rsp_ready.
// Option: define ALU_SEQ_SELFCHECK_EN to build the alu_e one-hot re-encode check; otherwise rsp_sel_err = 0.
module alu_op_sequencer #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [3:0]       alu_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [15:0]      alu_e,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_op,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_cout,
  output logic             rsp_sel_err,
  output logic             busy
);

  // The settle counter is 4 bits; anything outside 0..15 cannot be represented.
  if (SETTLE_CYCLES < 0 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("alu_op_sequencer: SETTLE_CYCLES=%0d outside legal range 0..15", SETTLE_CYCLES);
  end

  localparam logic [3:0] LP_SETTLE = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_cnt;
  logic             w_accept;
  logic             w_capture;
  logic             w_sel_err;

  logic [3:0]       r_alu_sel;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [3:0]       r_rsp_op;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_cout;
  logic             r_rsp_sel_err;

  // State register; reset aborts any op in flight and drops a pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and strobes: accept only in IDLE, capture when the settle count is exhausted.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_cnt == 4'd0) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        // Return to IDLE only; the next request is taken a cycle later.
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Settle counter: loaded on accept, counts down while the ALU inputs are held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
    end else if (w_accept) begin
      r_cnt <= LP_SETTLE;
    end else if (r_state == S_SETTLE && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Issue registers: ALU drive and op tag hold until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_sel <= 4'd0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_rsp_op  <= 4'd0;
    end else if (w_accept) begin
      r_alu_sel <= req_op;
      r_alu_a   <= req_a;
      r_alu_b   <= req_b;
      r_rsp_op  <= req_op;
    end
  end

  // Response registers: sampled once at capture; not cleared on return to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_result  <= '0;
      r_rsp_cout    <= 1'b0;
      r_rsp_sel_err <= 1'b0;
    end else if (w_capture) begin
      r_rsp_result  <= alu_result;
      r_rsp_cout    <= alu_cout;
      r_rsp_sel_err <= w_sel_err;
    end
  end

`ifdef ALU_SEQ_SELFCHECK_EN
  logic [3:0] w_enc;
  logic       w_onehot;

  // 16-to-4 priority encoder over the ALU decode; the highest set bit wins.
  always_comb begin
    w_enc = 4'd0;
    for (int k = 0; k < 16; k++) begin
      if (alu_e[k]) begin
        w_enc = 4'(k);
      end
    end
  end

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  assign w_onehot  = (alu_e != 16'd0) && ((alu_e & (alu_e - 16'd1)) == 16'd0);
  assign w_sel_err = !w_onehot || (w_enc != r_rsp_op);
`else
  logic w_unused_alu_e;
  assign w_unused_alu_e = ^alu_e;
  assign w_sel_err      = 1'b0;
`endif

  assign req_ready   = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign rsp_valid   = (r_state == S_RESP);
  assign alu_sel     = r_alu_sel;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign rsp_op      = r_rsp_op;
  assign rsp_result  = r_rsp_result;
  assign rsp_cout    = r_rsp_cout;
  assign rsp_sel_err = r_rsp_sel_err;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural 16-function ALU, vector table, scoreboard monitor,
// hand sequences for backpressure, decode errors, mid-op reset and the zero-settle build.
module tb_alu_op_sequencer;

`ifdef ALU_SEQ_SELFCHECK_EN
  localparam logic SELFCHK = 1'b1;
`else
  localparam logic SELFCHK = 1'b0;
`endif
  localparam int SETTLE = 1;

  typedef struct {
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] res;
    logic       cout;
  } vec_t;

  typedef struct {
    logic [3:0] op;
    logic [3:0] res;
    logic       cout;
    logic       err;
    int         acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t sb[$];

  // Main instance (SETTLE_CYCLES = 1)
  logic        req_valid, req_ready, alu_cout, rsp_valid, rsp_ready, rsp_cout, rsp_sel_err, busy;
  logic [3:0]  req_op, req_a, req_b, alu_sel, alu_a, alu_b, alu_result, rsp_op, rsp_result;
  logic [15:0] alu_e, e_force;
  logic        e_force_en;

  // Zero-settle instance
  logic        req0_valid, req0_ready, alu0_cout, rsp0_valid, rsp0_ready, rsp0_cout, rsp0_sel_err, busy0;
  logic [3:0]  req0_op, req0_a, req0_b, alu0_sel, alu0_a, alu0_b, alu0_result, rsp0_op, rsp0_result;
  logic [15:0] alu0_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_op_sequencer #(.WIDTH(4), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_e(alu_e),
    .alu_result(alu_result), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op), .rsp_result(rsp_result),
    .rsp_cout(rsp_cout), .rsp_sel_err(rsp_sel_err), .busy(busy)
  );

  alu_op_sequencer #(.WIDTH(4), .SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req0_valid), .req_ready(req0_ready), .req_op(req0_op), .req_a(req0_a), .req_b(req0_b),
    .alu_sel(alu0_sel), .alu_a(alu0_a), .alu_b(alu0_b), .alu_e(alu0_e),
    .alu_result(alu0_result), .alu_cout(alu0_cout),
    .rsp_valid(rsp0_valid), .rsp_ready(rsp0_ready), .rsp_op(rsp0_op), .rsp_result(rsp0_result),
    .rsp_cout(rsp0_cout), .rsp_sel_err(rsp0_sel_err), .busy(busy0)
  );

  // Behavioural ALU: returns {cout, result}
  function automatic logic [4:0] alu_f(input logic [3:0] s, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] t;
    t = 5'd0;
    case (s)
      4'd0:  t = {1'b0, a & b};
      4'd1:  t = {1'b0, a | b};
      4'd2:  t = {1'b0, a ^ b};
      4'd3:  t = {1'b0, ~a};
      4'd4:  t = {1'b0, a} + {1'b0, b};
      4'd5:  t = {1'b0, a} + {1'b0, ~b} + 5'd1;
      4'd6:  t = {1'b0, a} + 5'd1;
      4'd7:  t = {1'b0, a} + 5'h0F;
      4'd8:  t = {1'b0, ~(a & b)};
      4'd9:  t = {1'b0, ~(a | b)};
      4'd10: t = {1'b0, ~(a ^ b)};
      4'd11: t = {1'b0, ~b};
      4'd12: t = {1'b0, a};
      4'd13: t = {1'b0, b};
      4'd14: t = {a[3], a[2:0], 1'b0};
      default: t = {a[0], 1'b0, a[3:1]};
    endcase
    return t;
  endfunction

  always_comb begin
    {alu_cout, alu_result} = alu_f(alu_sel, alu_a, alu_b);
    alu_e = e_force_en ? e_force : (16'd1 << alu_sel);
    {alu0_cout, alu0_result} = alu_f(alu0_sel, alu0_a, alu0_b);
    alu0_e = 16'd1 << alu0_sel;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops on each response handshake
  logic prev_v  = 1'b0;
  int   first_v = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rsp_valid && !prev_v) first_v = cyc;
    prev_v = rsp_valid;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp: got op=%0h with empty scoreboard", rsp_op);
      end else begin
        e = sb.pop_front();
        chk("rsp_op", rsp_op, e.op);
        chk("rsp_result", rsp_result, e.res);
        chk("rsp_cout", rsp_cout, e.cout);
        chk("rsp_sel_err", rsp_sel_err, e.err);
        chk("latency", first_v - e.acc, SETTLE + 1);
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] res, input logic cout, input logic err);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", req_ready, 1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    e.op = op; e.res = res; e.cout = cout; e.err = err; e.acc = cyc;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", sb.size(), 0);
  endtask

  // Zero-settle op: response visible one cycle after accept, then req_ready returns
  task automatic send0(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] res, input logic cout);
    int n;
    @(posedge clk); #1;
    req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req0_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req0_ready) begin
      chk("s0_req_ready_timeout", req0_ready, 1);
      req0_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    chk("s0_valid_early", rsp0_valid, 0);
    @(negedge clk);
    chk("s0_valid", rsp0_valid, 1);
    chk("s0_op", rsp0_op, op);
    chk("s0_result", rsp0_result, res);
    chk("s0_cout", rsp0_cout, cout);
    chk("s0_sel_err", rsp0_sel_err, 0);
    @(negedge clk);
    chk("s0_valid_drop", rsp0_valid, 0);
    chk("s0_req_ready", req0_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vt [16];
    logic [4:0] m;

    vt[0]  = '{4'h4, 4'hF, 4'h1, 4'h0, 1'b1};
    vt[1]  = '{4'h0, 4'hC, 4'hA, 4'h8, 1'b0};
    vt[2]  = '{4'h1, 4'hC, 4'hA, 4'hE, 1'b0};
    vt[3]  = '{4'h2, 4'hC, 4'hA, 4'h6, 1'b0};
    vt[4]  = '{4'h3, 4'h5, 4'h0, 4'hA, 1'b0};
    vt[5]  = '{4'h5, 4'h3, 4'h5, 4'hE, 1'b0};
    vt[6]  = '{4'h5, 4'h5, 4'h3, 4'h2, 1'b1};
    vt[7]  = '{4'h6, 4'hF, 4'h0, 4'h0, 1'b1};
    vt[8]  = '{4'h7, 4'h5, 4'h3, 4'h4, 1'b1};
    vt[9]  = '{4'hE, 4'h9, 4'h0, 4'h2, 1'b1};
    vt[10] = '{4'hF, 4'h9, 4'h0, 4'h4, 1'b1};
    vt[11] = '{4'hA, 4'hC, 4'hA, 4'h9, 1'b0};
    vt[12] = '{4'h8, 4'hC, 4'hA, 4'h7, 1'b0};
    vt[13] = '{4'hC, 4'h6, 4'h3, 4'h6, 1'b0};
    vt[14] = '{4'hD, 4'h6, 4'h3, 4'h3, 1'b0};
    vt[15] = '{4'h9, 4'hC, 4'hA, 4'h1, 1'b0};

    rst_n = 1'b0;
    req_valid = 1'b0; req_op = 4'd0; req_a = 4'd0; req_b = 4'd0; rsp_ready = 1'b1;
    e_force_en = 1'b0; e_force = 16'd0;
    req0_valid = 1'b0; req0_op = 4'd0; req0_a = 4'd0; req0_b = 4'd0; rsp0_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_sel", alu_sel, 0);
    chk("rst_rsp_result", rsp_result, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);

    // Single op 7 with its natural one-hot decode
    send(4'h7, 4'h5, 4'h3, 4'h4, 1'b1, 1'b0);
    drain();

    // Vector table
    for (int i = 0; i < 16; i++) send(vt[i].op, vt[i].a, vt[i].b, vt[i].res, vt[i].cout, 1'b0);
    drain();

    // All 16 ops back to back, expectations from the ALU model
    for (int k = 0; k < 16; k++) begin
      m = alu_f(4'(k), 4'hF, 4'h1);
      send(4'(k), 4'hF, 4'h1, m[3:0], m[4], 1'b0);
    end
    drain();

    // Decode self-check: multi-hot, zero, wrong one-hot
    e_force_en = 1'b1;
    e_force = 16'h0081;
    send(4'h7, 4'h5, 4'h3, 4'h4, 1'b1, SELFCHK);
    drain();
    e_force = 16'h0000;
    send(4'h7, 4'h5, 4'h3, 4'h4, 1'b1, SELFCHK);
    drain();
    e_force = 16'h0040;
    send(4'h7, 4'h5, 4'h3, 4'h4, 1'b1, SELFCHK);
    drain();
    e_force = 16'h0080;
    send(4'h7, 4'h5, 4'h3, 4'h4, 1'b1, 1'b0);
    drain();
    e_force_en = 1'b0;

    // Backpressure: response held 5 cycles, a request pulsed meanwhile is ignored
    rsp_ready = 1'b0;
    send(4'h2, 4'hC, 4'h5, 4'h9, 1'b0, 1'b0);
    for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_result", rsp_result, 4'h9);
      chk("bp_op", rsp_op, 4'h2);
      chk("bp_req_ready", req_ready, 0);
      if (i == 1) begin
        req_op = 4'h0; req_a = 4'hF; req_b = 4'hF; req_valid = 1'b1;
      end
      if (i == 3) req_valid = 1'b0;
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("hs_req_ready", req_ready, 0);
    @(negedge clk);
    chk("post_hs_req_ready", req_ready, 1);
    chk("post_hs_valid", rsp_valid, 0);
    repeat (3) @(negedge clk);
    chk("ignored_req_busy", busy, 0);
    chk("ignored_req_sb", sb.size(), 0);

    // Reset during SETTLE
    send(4'hB, 4'h9, 4'h6, 4'h9, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_alu_sel", alu_sel, 0);
    chk("mid_rst_alu_a", alu_a, 0);
    chk("mid_rst_alu_b", alu_b, 0);
    chk("mid_rst_rsp_op", rsp_op, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", rsp_valid, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_valid", rsp_valid, 0);
      chk("post_rst_req_ready", req_ready, 1);
    end

    // Zero-settle instance
    send0(4'h4, 4'h7, 4'h8, 4'hF, 1'b0);
    send0(4'h6, 4'hF, 4'h0, 4'h0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
